// File: rtl/fetch_unit_pkg.sv
// Shared front-end definitions: next-PC select codes, fetch FSM states and
// the NOP word used whenever IF/ID must carry a bubble.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ADDR_SEQ     = 2'b00,
    ADDR_JUMP    = 2'b01,
    ADDR_BRANCH  = 2'b10,
    ADDR_SEQ_ALT = 2'b11
  } addr_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_DRAIN = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus. One request outstanding at a time;
// the response may come back in the request cycle or any later cycle.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Next-PC target select. Jumps take their upper nibble from the PC+4 of the
// jump instruction sitting in IF/ID, not from the current fetch PC.
module next_pc_mux
  import fetch_unit_pkg::*;
(
  input  logic [1:0]  addr_sel,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] if_id_pcplus4,
  input  logic [25:0] jump_index,
  input  logic [31:0] branch_target,
  output logic [31:0] next_pc,
  output logic        is_redirect_sel
);

  // Select target; code 11 falls through to sequential
  always_comb begin
    next_pc         = pc_plus4;
    is_redirect_sel = 1'b0;
    case (addr_sel)
      ADDR_JUMP: begin
        next_pc         = {if_id_pcplus4[31:28], jump_index, 2'b00};
        is_redirect_sel = 1'b1;
      end
      ADDR_BRANCH: begin
        next_pc         = branch_target;
        is_redirect_sel = 1'b1;
      end
      default: begin
        next_pc         = pc_plus4;
        is_redirect_sel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// IF-stage sequencer: owns the PC, issues instruction fetches, parks a word
// returned during a stall in a hold buffer, and drains the stale response of a
// fetch that was overtaken by a jump/branch redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
  input  logic                Clk,
  input  logic                Rst,
  fetch_unit_if.master        imem,
  input  logic                PC_Write,
  input  logic                IF_Write,
  input  logic                bubble,
  input  logic [1:0]          addrSel,
  input  logic [25:0]         JumpIndex,
  input  logic [31:0]         BranchTarget,
  output logic [31:0]         IF_ID_Instr,
  output logic [31:0]         IF_ID_PCPlus4,
  output logic                IF_ID_Valid,
  output logic                FetchStall,
  output logic [31:0]         PC
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcp4_q, pcp4_d;
  logic         vld_q, vld_d;
  logic         req_q, req_d;

  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc;
  logic         redirect_sel;
  logic         redirect;
  logic         avail;
  logic         accept;
  logic [31:0]  word;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc_mux u_next_pc_mux (
    .addr_sel        (addrSel),
    .pc_plus4        (pc_plus4),
    .if_id_pcplus4   (pcp4_q),
    .jump_index      (JumpIndex),
    .branch_target   (BranchTarget),
    .next_pc         (next_pc),
    .is_redirect_sel (redirect_sel)
  );

  // Hazard decode: is an instruction available, and does IF/ID take it
  always_comb begin
    redirect = PC_Write && redirect_sel;
    avail    = ((state_q == ST_FETCH) && imem.imem_valid) || (state_q == ST_HOLD);
    word     = (state_q == ST_HOLD) ? hold_q : imem.imem_rdata;
    accept   = avail && PC_Write && IF_Write && !bubble && !redirect_sel;
  end

  // Next-state logic for PC, IF/ID, hold buffer and fetch FSM
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    vld_d   = vld_q;

    if (redirect || accept) begin
      pc_d = next_pc;
    end

    // A NOP load keeps PC+4 so a following jump still sees its own PC+4
    if (accept) begin
      instr_d = word;
      pcp4_d  = pc_plus4;
      vld_d   = 1'b1;
    end else if (redirect || IF_Write) begin
      instr_d = NOP_INSTR;
      vld_d   = 1'b0;
    end

    case (state_q)
      ST_FETCH: begin
        if (redirect) begin
          state_d = imem.imem_valid ? ST_FETCH : ST_DRAIN;
        end else if (!accept && imem.imem_valid) begin
          hold_d  = imem.imem_rdata;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect || accept) state_d = ST_FETCH;
      end
      ST_DRAIN: begin
        if (imem.imem_valid) state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    req_d = (state_d == ST_FETCH);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
      instr_q <= NOP_INSTR;
      pcp4_q  <= 32'h0;
      vld_q   <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign FetchStall     = !avail && (state_q != ST_HOLD);
  assign IF_ID_Instr    = instr_q;
  assign IF_ID_PCPlus4  = pcp4_q;
  assign IF_ID_Valid    = vld_q;
  assign PC             = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the instruction memory by
// hand, one table row per clock cycle, with hand-computed expected values.
module tb_fetch_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        Clk;
  logic        Rst;
  logic        PC_Write;
  logic        IF_Write;
  logic        bubble;
  logic [1:0]  addrSel;
  logic [25:0] JumpIndex;
  logic [31:0] BranchTarget;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic        FetchStall;
  logic [31:0] PC;

  fetch_unit_if mif ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .imem          (mif),
    .PC_Write      (PC_Write),
    .IF_Write      (IF_Write),
    .bubble        (bubble),
    .addrSel       (addrSel),
    .JumpIndex     (JumpIndex),
    .BranchTarget  (BranchTarget),
    .IF_ID_Instr   (IF_ID_Instr),
    .IF_ID_PCPlus4 (IF_ID_PCPlus4),
    .IF_ID_Valid   (IF_ID_Valid),
    .FetchStall    (FetchStall),
    .PC            (PC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        rstn, pcw, ifw, bub;
    logic [1:0]  sel;
    logic [25:0] jidx;
    logic [31:0] btgt;
    logic        mv;
    logic [31:0] md;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_v;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic vec_t mk(input logic rstn, input logic pcw, input logic ifw,
                              input logic bub, input logic [1:0] sel,
                              input logic [25:0] jidx, input logic [31:0] btgt,
                              input logic mv, input logic [31:0] md,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_stall, input logic [31:0] e_pc,
                              input logic [31:0] e_instr, input logic [31:0] e_p4,
                              input logic e_v);
    vec_t v;
    v.rstn = rstn; v.pcw = pcw; v.ifw = ifw; v.bub = bub; v.sel = sel;
    v.jidx = jidx; v.btgt = btgt; v.mv = mv; v.md = md;
    v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_p4 = e_p4; v.e_v = e_v;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check registers
  task automatic step(input vec_t v, input int idx);
    @(negedge Clk);
    Rst             = v.rstn;
    PC_Write        = v.pcw;
    IF_Write        = v.ifw;
    bubble          = v.bub;
    addrSel         = v.sel;
    JumpIndex       = v.jidx;
    BranchTarget    = v.btgt;
    mif.imem_valid  = v.mv;
    mif.imem_rdata  = v.md;
    #1;
    chk("imem_req",   idx, 32'(mif.imem_req), 32'(v.e_req));
    chk("imem_addr",  idx, mif.imem_addr,     v.e_addr);
    chk("FetchStall", idx, 32'(FetchStall),   32'(v.e_stall));
    @(posedge Clk);
    #1;
    chk("PC",            idx, PC,               v.e_pc);
    chk("IF_ID_Instr",   idx, IF_ID_Instr,      v.e_instr);
    chk("IF_ID_PCPlus4", idx, IF_ID_PCPlus4,    v.e_p4);
    chk("IF_ID_Valid",   idx, 32'(IF_ID_Valid), 32'(v.e_v));
  endtask

  initial begin
    // Reset with junk on the hazard inputs and a pending response
    Rst = 1'b0; PC_Write = 1'b1; IF_Write = 1'b1; bubble = 1'b0;
    addrSel = 2'b10; JumpIndex = 26'h3FF_FFFF; BranchTarget = 32'h1234_5678;
    mif.imem_valid = 1'b0; mif.imem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge Clk);
    #1;
    addrSel = 2'b00;
    #1;
    chk("rst PC",            0, PC,                   32'h0);
    chk("rst imem_req",      0, 32'(mif.imem_req),    32'h1);
    chk("rst imem_addr",     0, mif.imem_addr,        32'h0);
    chk("rst IF_ID_Instr",   0, IF_ID_Instr,          32'h0);
    chk("rst IF_ID_PCPlus4", 0, IF_ID_PCPlus4,        32'h0);
    chk("rst IF_ID_Valid",   0, 32'(IF_ID_Valid),     32'h0);
    chk("rst FetchStall",    0, 32'(FetchStall),      32'h1);

    // Zero-latency streaming: addr 0,4,8,C
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0000, H,32'h0, L, 32'h4, 32'hA000_0000,32'h4, H));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0004, H,32'h4, L, 32'h8, 32'hA000_0004,32'h8, H));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0008, H,32'h8, L, 32'hC, 32'hA000_0008,32'hC, H));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_000C, H,32'hC, L, 32'h10,32'hA000_000C,32'h10,H));
    // Slow memory at 0x10: two stall cycles then the word
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         H,32'h10,H, 32'h10,32'h0,        32'h10,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         H,32'h10,H, 32'h10,32'h0,        32'h10,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0010, H,32'h10,L, 32'h14,32'hA000_0010,32'h14,H));
    // Stall with a returned word: HOLD, then release
    tbl.push_back(mk(H,L,L,L,2'b00,26'h0,32'h0,H,32'hA000_0014, H,32'h14,L, 32'h14,32'hA000_0010,32'h14,H));
    tbl.push_back(mk(H,L,L,L,2'b00,26'h0,32'h0,L,32'h0,         L,32'h14,L, 32'h14,32'hA000_0010,32'h14,H));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         L,32'h14,L, 32'h18,32'hA000_0014,32'h18,H));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0018, H,32'h18,L, 32'h1C,32'hA000_0018,32'h1C,H));
    // Bubble parks the word in HOLD, next cycle consumes it
    tbl.push_back(mk(H,H,H,H,2'b00,26'h0,32'h0,H,32'hA000_001C, H,32'h1C,L, 32'h1C,32'h0,        32'h1C,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         L,32'h1C,L, 32'h20,32'hA000_001C,32'h20,H));
    // Branch while a fetch is outstanding: drain stale response, refetch at 0x80
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         H,32'h20,H, 32'h20,32'h0,        32'h20,L));
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'h80,L,32'h0,        H,32'h20,H, 32'h80,32'h0,        32'h20,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hDEAD_0000, L,32'h80,H, 32'h80,32'h0,        32'h20,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0080, H,32'h80,L, 32'h84,32'hA000_0080,32'h84,H));
    // Branch with response in the same cycle: discard, stay fetching
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'h100,H,32'hA000_0084,H,32'h84,L,32'h100,32'h0,       32'h84,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0100, H,32'h100,L,32'h104,32'hA000_0100,32'h104,H));
    // Jump from an instruction with PC+4 = 0x00400010
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'h0040_000C,H,32'h0, H,32'h104,L,32'h0040_000C,32'h0,32'h104,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA040_000C, H,32'h0040_000C,L,32'h0040_0010,32'hA040_000C,32'h0040_0010,H));
    tbl.push_back(mk(H,H,H,L,2'b01,26'h0000100,32'h0,H,32'hA040_0010,H,32'h0040_0010,L,32'h400,32'h0,32'h0040_0010,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0400, H,32'h400,L,32'h404,32'hA000_0400,32'h404,H));
    // PC+4 wraps at the top of the address space
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'hFFFF_FFFC,H,32'h0, H,32'h404,L,32'hFFFF_FFFC,32'h0,32'h404,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_00FC, H,32'hFFFF_FFFC,L,32'h0,32'hA000_00FC,32'h0,H));
    // Jump keeps the upper nibble of IF/ID PC+4; redirect during DRAIN
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'h9000_0000,H,32'h0, H,32'h0,L,32'h9000_0000,32'h0,32'h0,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'h1111_1111, H,32'h9000_0000,L,32'h9000_0004,32'h1111_1111,32'h9000_0004,H));
    tbl.push_back(mk(H,H,H,L,2'b01,26'h3FF_FFFF,32'h0,L,32'h0,  H,32'h9000_0004,H,32'h9FFF_FFFC,32'h0,32'h9000_0004,L));
    tbl.push_back(mk(H,H,H,L,2'b10,26'h0,32'h200,L,32'h0,       L,32'h9FFF_FFFC,H,32'h200,32'h0,32'h9000_0004,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hBAD0_BAD0, L,32'h200,H,32'h200,32'h0,32'h9000_0004,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0200, H,32'h200,L,32'h204,32'hA000_0200,32'h204,H));
    // addrSel 11 behaves as sequential
    tbl.push_back(mk(H,H,H,L,2'b11,26'h0,32'h0,H,32'hA000_0204, H,32'h204,L,32'h208,32'hA000_0204,32'h208,H));
    // PC_Write=0 ignores a jump select; word goes to HOLD, IF/ID gets NOP
    tbl.push_back(mk(H,L,H,L,2'b01,26'h0000123,32'h0,H,32'hA000_0208,H,32'h208,L,32'h208,32'h0,32'h208,L));
    // Redirect from HOLD drops the held word even with IF_Write=0
    tbl.push_back(mk(H,H,L,L,2'b10,26'h0,32'h300,L,32'h0,       L,32'h208,L,32'h300,32'h0,32'h208,L));
    tbl.push_back(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0300, H,32'h300,L,32'h304,32'hA000_0300,32'h304,H));

    foreach (tbl[i]) step(tbl[i], i + 1);

    // Reset asserted while in HOLD at PC=0x20
    step(mk(H,H,H,L,2'b10,26'h0,32'h20,H,32'h0,        H,32'h304,L,32'h20,32'h0,32'h304,L), 100);
    step(mk(H,L,L,L,2'b00,26'h0,32'h0,H,32'hA000_0020, H,32'h20, L,32'h20,32'h0,32'h304,L), 101);
    step(mk(L,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         L,32'h20, L,32'h0, 32'h0,32'h0,  L), 102);
    step(mk(H,H,H,L,2'b00,26'h0,32'h0,L,32'h0,         H,32'h0,  H,32'h0, 32'h0,32'h0,  L), 103);
    step(mk(H,H,H,L,2'b00,26'h0,32'h0,H,32'hA000_0000, H,32'h0,  L,32'h4, 32'hA000_0000,32'h4,H), 104);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- IF-stage sequencer on the consuming side of the pipeline hazard controls.
- Owns the PC, drives the instruction-memory request interface, and loads the IF/ID pipeline register.
- Obeys PC_Write, IF_Write, bubble and addrSel from the hazard unit.
- Buffers a returned instruction while the front end is stalled, and squashes or drains wrong-path fetches on jump/branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble/squash.

Ports:
- Clk  in  1  clock; all state updates on posedge
- Rst  in  1  synchronous active-low reset
- PC_Write  in  1  hazard unit: PC may advance/redirect this cycle
- IF_Write  in  1  hazard unit: IF/ID may load this cycle
- bubble  in  1  hazard unit: load NOP into IF/ID
- addrSel  in  2  next-PC select: 00 PC+4, 01 jump, 10 branch, 11 treated as 00
- JumpIndex  in  26  instr_index field of jump in ID
- BranchTarget  in  32  resolved branch target from EX
- imem_req  out  1  instruction fetch request (level)
- imem_addr  out  32  fetch address, equals PC
- imem_valid  in  1  response valid for the outstanding request
- imem_rdata  in  32  instruction word, qualified by imem_valid
- IF_ID_Instr  out  32  IF/ID instruction register
- IF_ID_PCPlus4  out  32  IF/ID PC+4 register
- IF_ID_Valid  out  1  IF/ID holds a real instruction
- FetchStall  out  1  IF has no instruction available this cycle
- PC  out  32  current PC register

Behaviour:
- Reset (Rst=0 at posedge): PC=RESET_PC, state=FETCH, hold buffer empty, IF_ID_Instr=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0. Reset overrides every other input, including mid-fetch or mid-drain; any in-flight response arriving after reset is treated as the response to the new request at RESET_PC. The memory contract requires that memory is reset together with this block.
- Memory protocol:
  - Requests are one at a time and in order.
  - imem_req=1 only in FETCH; imem_addr=PC (combinational).
  - Memory latches the address in the first req cycle.
  - imem_valid may arrive in the same cycle (zero-latency memory) or any later cycle.
- Instruction available: avail = (FETCH and imem_valid) or HOLD. The word is imem_rdata or hold_buf respectively. FetchStall = not avail and state != HOLD.
- Next PC:
  - 01: {IF_ID_PCPlus4[31:28], JumpIndex, 2'b00}.
  - 10: BranchTarget.
  - 00/11: PC+4, modulo 2^32 (wraps at 32'hFFFF_FFFC).
- States: FETCH, HOLD, DRAIN.
- FETCH, redirect (PC_Write=1, addrSel in {01,10}):
  - PC loads target; IF/ID loads NOP (Valid=0).
  - If imem_valid=1: response discarded, stay FETCH.
  - Else: go DRAIN.
- FETCH, sequential accept (avail, PC_Write=1, IF_Write=1, bubble=0, addrSel 00):
  - IF/ID loads {imem_rdata, PC+4, Valid=1}; PC loads PC+4; stay FETCH. Full throughput is 1 instr/cycle with zero-latency memory.
- FETCH, imem_valid=1 but IF_Write=0 or PC_Write=0 (no redirect): hold_buf loads imem_rdata; go HOLD; PC unchanged.
- FETCH, imem_valid=0 and no redirect: PC holds. If IF_Write=1, IF/ID loads NOP/Valid=0.
- HOLD: imem_req=0.
  - Redirect: drop hold_buf, PC loads target, IF/ID loads NOP, go FETCH.
  - Sequential accept: IF/ID loads {hold_buf, PC+4, 1}, PC loads PC+4, go FETCH.
  - Otherwise stay HOLD.
- DRAIN: imem_req=0; wait for imem_valid, discard the data, go FETCH. A redirect during DRAIN updates PC only and stays DRAIN. IF/ID loads NOP whenever IF_Write=1.
- bubble=1 takes priority over any IF/ID load: IF/ID gets NOP/Valid=0. It does not consume an available instruction; the instruction goes to hold_buf/HOLD.
- IF_Write=0 and no redirect: IF/ID registers are unchanged.
- PC_Write=0: PC unchanged regardless of addrSel.

Decomposition:
- Shared pipeline package holds:
  - addrSel encodings (ADDR_SEQ=2'b00, ADDR_JUMP=2'b01, ADDR_BRANCH=2'b10);
  - fetch state encodings;
  - NOP_INSTR constant.
- One sub-module: next_pc_mux, a combinational target select/jump concatenation. The FSM, hold buffer and IF/ID register stay in fetch_unit.

Test Plan:
- Reset, then zero-latency memory, all enables 1 -> imem_addr 0,4,8,C on consecutive cycles; IF_ID_PCPlus4 4,8,C; IF_ID_Valid=1 from cycle 2.
- Memory latency 3 cycles -> FetchStall=1 for 2 cycles; IF_ID_Valid=0 during stall; PC stays 0 until word arrives.
- IF_Write=PC_Write=0 for 2 cycles while imem_valid=1 at PC=8 -> HOLD, imem_req=0; on release IF_ID_Instr=held word, PC=C.
- Jump: JumpIndex=26'h0000100, IF_ID_PCPlus4=32'h0040_0010, addrSel=01, PC_Write=1 -> PC=32'h0000_0400, IF_ID_Valid=0.
- Branch redirect with 2-cycle-latency fetch outstanding, BranchTarget=32'h80 -> DRAIN, late response discarded; next request addr=32'h80.
- Rst=0 asserted in HOLD at PC=32'h20 -> next cycle PC=RESET_PC, IF_ID_Valid=0, state FETCH, imem_req=1.
